// File: rtl/mouse_cursor_tracker.sv
// mouse_cursor_tracker
// Decodes 3-byte PS/2 stream packets into a clamped cursor cell position and
// button levels for the drawing circuit. Motion accumulates in a fine
// (sub-cell) position so FRAC_BITS sets the mouse sensitivity.
module mouse_cursor_tracker #(
    parameter int SCREEN_WIDTH   = 640,
    parameter int SCREEN_HEIGHT  = 480,
    parameter int CELL_DIMENSION = 5,
    parameter int UPPER_BITS     = $clog2(((SCREEN_WIDTH / CELL_DIMENSION) > (SCREEN_HEIGHT / CELL_DIMENSION))
                                          ? (SCREEN_WIDTH / CELL_DIMENSION) : (SCREEN_HEIGHT / CELL_DIMENSION)),
    parameter int FRAC_BITS      = 2,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                  iClk,
    input  logic                  iResetn,
    input  logic [7:0]            iData,
    input  logic                  iDataValid,
    input  logic                  iStreaming,
    output logic [UPPER_BITS-1:0] oX_cell,
    output logic [UPPER_BITS-1:0] oY_cell,
    output logic                  oLeftbtn,
    output logic                  oRightbtn,
    output logic                  oPacketValid,
    output logic                  oSyncError
);

    localparam int CELLS_X = SCREEN_WIDTH / CELL_DIMENSION;
    localparam int CELLS_Y = SCREEN_HEIGHT / CELL_DIMENSION;
    localparam int FINE_W  = UPPER_BITS + FRAC_BITS;
    localparam int SUM_W   = FINE_W + 2;
    localparam int CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int X_MAX   = (CELLS_X << FRAC_BITS) - 1;
    localparam int Y_MAX   = (CELLS_Y << FRAC_BITS) - 1;

    localparam logic signed [SUM_W-1:0] X_MAX_S = SUM_W'(X_MAX);
    localparam logic signed [SUM_W-1:0] Y_MAX_S = SUM_W'(Y_MAX);
    localparam logic [FINE_W-1:0]       X_RST   = FINE_W'((CELLS_X / 2) << FRAC_BITS);
    localparam logic [FINE_W-1:0]       Y_RST   = FINE_W'((CELLS_Y / 2) << FRAC_BITS);
    localparam logic [CNT_W-1:0]        CNT_END = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, UPDATE} state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    // Only the b0 fields that matter are kept
    logic              left_b0_reg, right_b0_reg;
    logic              xsign_reg, ysign_reg, xovf_reg, yovf_reg;
    logic [7:0]        dx_lo_reg, dy_lo_reg;
    // Fine position and the button levels of the last good packet
    logic [FINE_W-1:0] xf_reg, yf_reg;
    logic              left_reg, right_reg;
    logic              upd_reg;

    logic signed [SUM_W-1:0] dx_ext, dy_ext, x_sum, y_sum;
    logic [FINE_W-1:0]       x_next, y_next;

    // New fine position from the latched packet, clamped to the screen
    always_comb begin
        dx_ext = xovf_reg ? '0 : {{(SUM_W-8){xsign_reg}}, dx_lo_reg};
        dy_ext = yovf_reg ? '0 : {{(SUM_W-8){ysign_reg}}, dy_lo_reg};
        // PS/2 +Y points up while screen +Y points down
        x_sum  = $signed({2'b00, xf_reg}) + dx_ext;
        y_sum  = $signed({2'b00, yf_reg}) - dy_ext;
        x_next = x_sum[FINE_W-1:0];
        y_next = y_sum[FINE_W-1:0];
        if (x_sum[SUM_W-1]) begin
            x_next = '0;
        end else if (x_sum > X_MAX_S) begin
            x_next = FINE_W'(X_MAX);
        end
        if (y_sum[SUM_W-1]) begin
            y_next = '0;
        end else if (y_sum > Y_MAX_S) begin
            y_next = FINE_W'(Y_MAX);
        end
    end

    // Packet FSM, timeout counter, position registers and registered outputs
    always_ff @(posedge iClk) begin
        if (!iResetn) begin
            state_reg    <= WAIT_B0;
            cnt_reg      <= '0;
            left_b0_reg  <= 1'b0;
            right_b0_reg <= 1'b0;
            xsign_reg    <= 1'b0;
            ysign_reg    <= 1'b0;
            xovf_reg     <= 1'b0;
            yovf_reg     <= 1'b0;
            dx_lo_reg    <= '0;
            dy_lo_reg    <= '0;
            xf_reg       <= X_RST;
            yf_reg       <= Y_RST;
            left_reg     <= 1'b0;
            right_reg    <= 1'b0;
            upd_reg      <= 1'b0;
            oX_cell      <= UPPER_BITS'(CELLS_X / 2);
            oY_cell      <= UPPER_BITS'(CELLS_Y / 2);
            oLeftbtn     <= 1'b0;
            oRightbtn    <= 1'b0;
            oPacketValid <= 1'b0;
            oSyncError   <= 1'b0;
        end else begin
            // Output stage trails the UPDATE state by one cycle
            oX_cell      <= xf_reg[FINE_W-1:FRAC_BITS];
            oY_cell      <= yf_reg[FINE_W-1:FRAC_BITS];
            oLeftbtn     <= left_reg;
            oRightbtn    <= right_reg;
            oPacketValid <= upd_reg;
            upd_reg      <= 1'b0;
            oSyncError   <= 1'b0;

            if (!iStreaming) begin
                state_reg <= WAIT_B0;
                cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    WAIT_B0: begin
                        cnt_reg <= '0;
                        if (iDataValid) begin
                            if (iData[3]) begin
                                left_b0_reg  <= iData[0];
                                right_b0_reg <= iData[1];
                                xsign_reg    <= iData[4];
                                ysign_reg    <= iData[5];
                                xovf_reg     <= iData[6];
                                yovf_reg     <= iData[7];
                                state_reg    <= WAIT_B1;
                            end else begin
                                oSyncError <= 1'b1;
                            end
                        end
                    end
                    WAIT_B1: begin
                        if (iDataValid) begin
                            dx_lo_reg <= iData;
                            cnt_reg   <= '0;
                            state_reg <= WAIT_B2;
                        end else if (cnt_reg == CNT_END) begin
                            cnt_reg   <= '0;
                            state_reg <= WAIT_B0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    WAIT_B2: begin
                        if (iDataValid) begin
                            dy_lo_reg <= iData;
                            cnt_reg   <= '0;
                            state_reg <= UPDATE;
                        end else if (cnt_reg == CNT_END) begin
                            cnt_reg   <= '0;
                            state_reg <= WAIT_B0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    UPDATE: begin
                        xf_reg    <= x_next;
                        yf_reg    <= y_next;
                        left_reg  <= left_b0_reg;
                        right_reg <= right_b0_reg;
                        upd_reg   <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= WAIT_B0;
                    end
                    default: begin
                        cnt_reg   <= '0;
                        state_reg <= WAIT_B0;
                    end
                endcase
            end
        end
    end

endmodule
